// File: rtl/cpu_pkg.sv
// Shared datapath definitions: ALU operation codes and the divider FSM state encoding.
package cpu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/alu32.sv
// 32-bit combinational ALU (AND/OR/ADD/SUB/SLT) with a zero flag.
module alu32
  import cpu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_alu_code,
  output logic [31:0] o_out,
  output logic        o_zero
);

  always_comb begin
    o_out = 32'd0;
    case (i_alu_code)
      ALU_AND: o_out = i_a & i_b;
      ALU_OR:  o_out = i_a | i_b;
      ALU_ADD: o_out = i_a + i_b;
      ALU_SUB: o_out = i_a - i_b;
      ALU_SLT: o_out = {31'd0, $signed(i_a) < $signed(i_b)};
      default: o_out = 32'd0;
    endcase
  end

  assign o_zero = (o_out == 32'd0);

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring 32-bit divider (DIV/DIVU), one quotient bit per cycle, using alu32
// as the trial subtractor. Remainder goes to HI, quotient to LO.
module div32_seq
  import cpu_pkg::*;
#(
  parameter int ITER  = 32,
  parameter int CNT_W = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_is_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_dz,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  div_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rem, r_quo, r_dvs, r_hi, r_lo;
  logic             r_dvd_neg, r_dvs_neg, r_dz_op, r_dz;

  logic        w_accept_start, w_dvd_neg, w_dvs_neg, w_borrow, w_accept;
  logic [31:0] w_dvd_mag, w_dvs_mag, w_diff;
  logic [32:0] w_s;
  logic        w_alu_zero_unused;

  assign w_accept_start = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_dvd_neg      = i_is_signed & i_dividend[31];
  assign w_dvs_neg      = i_is_signed & i_divisor[31];
  assign w_dvd_mag      = w_dvd_neg ? (32'd0 - i_dividend) : i_dividend;
  assign w_dvs_mag      = w_dvs_neg ? (32'd0 - i_divisor) : i_divisor;

  assign w_s = {r_rem, r_quo[31]};

  alu32 u_alu (
    .i_a        (w_s[31:0]),
    .i_b        (r_dvs),
    .i_alu_code (ALU_SUB),
    .o_out      (w_diff),
    .o_zero     (w_alu_zero_unused)
  );

  // Unsigned borrow of S[31:0]-b from the MSBs; bit 32 of S always permits the subtract.
  assign w_borrow = (~w_s[31] & r_dvs[31]) | (~(w_s[31] ^ r_dvs[31]) & w_diff[31]);
  assign w_accept = w_s[32] | ~w_borrow;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = i_start ? S_CALC : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_dvs     <= 32'd0;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_dz_op   <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else if (w_accept_start) begin
      r_cnt     <= CNT_W'(ITER - 1);
      r_rem     <= 32'd0;
      r_quo     <= w_dvd_mag;
      r_dvs     <= w_dvs_mag;
      r_dvd_neg <= w_dvd_neg;
      r_dvs_neg <= w_dvs_neg;
      r_dz_op   <= (i_divisor == 32'd0);
    end else if (r_state == S_CALC) begin
      r_rem <= w_accept ? w_diff : w_s[31:0];
      r_quo <= {r_quo[30:0], w_accept};
      r_cnt <= r_cnt - 1'b1;
    end else if (r_state == S_FIX) begin
      r_dz <= r_dz_op;
      // With a zero divisor every step accepts, so R ends as |dividend|; re-signing restores the operand.
      r_hi <= r_dvd_neg ? (32'd0 - r_rem) : r_rem;
      if (r_dz_op) r_lo <= 32'hFFFF_FFFF;
      else         r_lo <= (r_dvd_neg ^ r_dvs_neg) ? (32'd0 - r_quo) : r_quo;
    end
  end

  assign o_busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign o_done = (r_state == S_DONE);
  assign o_dz   = r_dz;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq: latency, signed/unsigned results, divide by zero,
// ignored starts, back-to-back issue and mid-operation reset.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div32_seq dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_is_signed (is_signed),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_busy      (busy),
    .o_done      (done),
    .o_dz        (dz),
    .o_hi        (hi),
    .o_lo        (lo)
  );

  // Presents one request across a single rising edge; returns 1 time unit after that edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded at 100).
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL rst_dz got=%b exp=0", dz); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL rst_hi got=%h exp=0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL rst_lo got=%h exp=0", lo); end
    @(negedge clk); reset = 1'b0;
    $display("reset: busy=%b done=%b dz=%b hi=%h lo=%h", busy, done, dz, hi, lo);
  endtask

  task automatic test_divu_basic;
    int n;
    int busy_bad;
    issue(1'b0, 32'd100, 32'd7);
    n = 0; busy_bad = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL divu_latency got=%0d exp=33 edges after start", n); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL divu_busy low_cycles got=%0d exp=0", busy_bad); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL divu_busy_in_done got=%b exp=0", busy); end
    n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got=%h exp=%h", lo, 32'd14); end
    n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL divu_hi got=%h exp=%h", hi, 32'd2); end
    n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL divu_dz got=%b exp=0", dz); end
    $display("divu 100/7: edges=%0d lo=%h hi=%h dz=%b", n, lo, hi, dz);
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL divu_done_pulse got=%b exp=0", done); end
    n_cmp++; if (lo !== 32'd14 || hi !== 32'd2) begin
      n_bad++; $display("FAIL divu_hold got lo=%h hi=%h exp lo=%h hi=%h", lo, hi, 32'd14, 32'd2);
    end
  endtask

  task automatic test_vectors;
    logic        v_s  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] v_a  [7] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1234, 32'hFFFFFFFB};
    logic [31:0] v_b  [7] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'd0, 32'd0};
    logic [31:0] v_lo [7] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] v_hi [7] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h7FFFFFFF, 32'd1234, 32'hFFFFFFFB};
    logic        v_dz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int n;
    for (int i = 0; i < 7; i++) begin
      issue(v_s[i], v_a[i], v_b[i]);
      wait_done(n);
      n_cmp++; if (n != 33) begin n_bad++; $display("FAIL vec%0d_latency got=%0d exp=33", i, n); end
      n_cmp++; if (lo !== v_lo[i]) begin n_bad++; $display("FAIL vec%0d_lo got=%h exp=%h", i, lo, v_lo[i]); end
      n_cmp++; if (hi !== v_hi[i]) begin n_bad++; $display("FAIL vec%0d_hi got=%h exp=%h", i, hi, v_hi[i]); end
      n_cmp++; if (dz !== v_dz[i]) begin n_bad++; $display("FAIL vec%0d_dz got=%b exp=%b", i, dz, v_dz[i]); end
      $display("vec%0d signed=%b %h/%h: lo=%h hi=%h dz=%b edges=%0d", i, v_s[i], v_a[i], v_b[i], lo, hi, dz, n);
    end
  endtask

  task automatic test_ignored_start;
    int n;
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    n_cmp++; if (n + 10 != 33) begin n_bad++; $display("FAIL ign_latency got=%0d exp=33", n + 10); end
    n_cmp++; if (lo !== 32'd14 || hi !== 32'd2) begin
      n_bad++; $display("FAIL ign_result got lo=%h hi=%h exp lo=%h hi=%h", lo, hi, 32'd14, 32'd2);
    end
    $display("ignored start: lo=%h hi=%h edges=%0d", lo, hi, n + 10);
  endtask

  task automatic test_back_to_back;
    int n;
    issue(1'b0, 32'd20, 32'd3);
    wait_done(n);
    n_cmp++; if (lo !== 32'd6 || hi !== 32'd2) begin
      n_bad++; $display("FAIL b2b_first got lo=%h hi=%h exp lo=%h hi=%h", lo, hi, 32'd6, 32'd2);
    end
    is_signed = 1'b1; dividend = 32'hFFFFFF9C; divisor = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept busy got=%b exp=1", busy); end
    wait_done(n);
    n_cmp++; if (n + 1 != 34) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=34", n + 1); end
    n_cmp++; if (lo !== 32'hFFFFFFF5 || hi !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL b2b_second got lo=%h hi=%h exp lo=%h hi=%h", lo, hi, 32'hFFFFFFF5, 32'hFFFFFFFF);
    end
    $display("back-to-back: -100/9 lo=%h hi=%h", lo, hi);
  endtask

  task automatic test_reset_mid;
    int n;
    issue(1'b0, 32'd100, 32'd7);
    wait_done(n);
    issue(1'b0, 32'd77, 32'd5);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0 0", busy, done);
    end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0 || dz !== 1'b0) begin
      n_bad++; $display("FAIL midrst_out got hi=%h lo=%h dz=%b exp 0 0 0", hi, lo, dz);
    end
    @(negedge clk); reset = 1'b0;
    issue(1'b0, 32'd1000, 32'd33);
    wait_done(n);
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL midrst_latency got=%0d exp=33", n); end
    n_cmp++; if (lo !== 32'd30 || hi !== 32'd10) begin
      n_bad++; $display("FAIL midrst_result got lo=%h hi=%h exp lo=%h hi=%h", lo, hi, 32'd30, 32'd10);
    end
    $display("reset mid-op then 1000/33: lo=%h hi=%h", lo, hi);
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_vectors;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
